// File: rtl/rv_ctrl_pkg.sv
// Shared types and RV32I opcode constants for the multicycle sequencer.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT} state_e;

  localparam logic [6:0] OpcodeLui    = 7'b0110111;
  localparam logic [6:0] OpcodeAuipc  = 7'b0010111;
  localparam logic [6:0] OpcodeJal    = 7'b1101111;
  localparam logic [6:0] OpcodeJalr   = 7'b1100111;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeFence  = 7'b0001111;
  localparam logic [6:0] OpcodeSystem = 7'b1110011;

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {PcPlus4 = 2'b00, PcBranch = 2'b01, PcJalr = 2'b10} pc_src_e;
  typedef enum logic [1:0] {WbAlu = 2'b00, WbMem = 2'b01, WbPc4 = 2'b10} wb_sel_e;
  typedef enum logic [1:0] {
    CauseNone    = 2'b00,
    CauseIllegal = 2'b01,
    CauseBus     = 2'b10,
    CauseTimeout = 2'b11
  } trap_cause_e;

  function automatic logic is_rv32i(input logic [6:0] op);
    case (op)
      OpcodeLui, OpcodeAuipc, OpcodeJal, OpcodeJalr, OpcodeBranch, OpcodeLoad,
      OpcodeStore, OpcodeOpImm, OpcodeOp, OpcodeFence, OpcodeSystem: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; flags when the next idle cycle would exceed the timeout.
module mem_wait_timer import rv_ctrl_pkg::*; #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic limit_o
);

  localparam logic [WAIT_W-1:0] Limit = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear_i) begin
      wait_cnt_d = '0;
    end else if (count_i) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign limit_o = (wait_cnt_q == Limit);

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port between
// instruction fetch and load/store.
module multicycle_seq_ctrl import rv_ctrl_pkg::*; #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 rd_zero,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  input  logic                 mem_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_sel_data,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] InstretOne = {{(INSTRET_W-1){1'b0}}, 1'b1};

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;
  pc_src_e     pc_src_v;
  wb_sel_e     wb_sel_v;

  logic [INSTRET_W-1:0] instret_q;
  logic                 retire;
  logic                 wait_en;
  logic                 wait_limit;
  logic                 timeout;

  assign wait_en = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
  assign timeout = wait_en && wait_limit;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(state_d != state_q),
    .count_i(wait_en),
    .limit_o(wait_limit)
  );

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    retire       = 1'b0;
    pc_src_v     = PcPlus4;
    wb_sel_v     = WbAlu;
    trap         = 1'b0;
    trap_cause   = 2'b00;
    halted       = 1'b0;

    // Outputs are forced quiet while reset is held so nothing half-issued escapes.
    if (!rst_n) begin
      state_d = FETCH;
      cause_d = CauseNone;
    end else begin
      trap       = (state_q == TRAP);
      halted     = (state_q == HALT);
      trap_cause = cause_q;
      unique case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            if (mem_err) begin
              state_d = TRAP;
              cause_d = CauseBus;
            end else begin
              ir_we   = 1'b1;
              state_d = DECODE;
            end
          end else if (timeout) begin
            state_d = TRAP;
            cause_d = CauseTimeout;
          end
        end
        DECODE: begin
          if (opcode == OpcodeSystem) begin
            state_d = HALT;
          end else if (!is_rv32i(opcode)) begin
            state_d = TRAP;
            cause_d = CauseIllegal;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          case (opcode)
            OpcodeBranch: begin
              pc_we    = 1'b1;
              pc_src_v = branch_taken ? PcBranch : PcPlus4;
              retire   = 1'b1;
              state_d  = FETCH;
            end
            OpcodeFence: begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = FETCH;
            end
            OpcodeLoad, OpcodeStore: state_d = MEM;
            default:                 state_d = WB;
          endcase
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_sel_data = 1'b1;
          mem_we       = (opcode == OpcodeStore);
          if (mem_ready) begin
            if (mem_err) begin
              state_d = TRAP;
              cause_d = CauseBus;
            end else if (opcode == OpcodeStore) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = FETCH;
            end else begin
              state_d = WB;
            end
          end else if (timeout) begin
            state_d = TRAP;
            cause_d = CauseTimeout;
          end
        end
        WB: begin
          reg_we  = !rd_zero;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
          case (opcode)
            OpcodeLoad:          wb_sel_v = WbMem;
            OpcodeJal:           begin wb_sel_v = WbPc4; pc_src_v = PcBranch; end
            OpcodeJalr:          begin wb_sel_v = WbPc4; pc_src_v = PcJalr;   end
            default:             wb_sel_v = WbAlu;
          endcase
        end
        TRAP, HALT: ;
        default: state_d = FETCH;
      endcase
    end
  end

  assign pc_src = pc_src_v;
  assign wb_sel = wb_sel_v;
  assign instret = instret_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      cause_q   <= CauseNone;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) begin
        instret_q <= instret_q + InstretOne;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Randomized bench for the multicycle sequencer against an instruction-level
// model that expands each instruction into its expected per-cycle outputs.
module tb_multicycle_seq_ctrl;

  localparam int unsigned MemTimeout = 255;
  localparam int unsigned InstretW   = 32;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [6:0]          opcode;
  logic                rd_zero, branch_taken, mem_ready, mem_err;
  logic                mem_req, mem_we, mem_sel_data, ir_we, pc_we, reg_we;
  logic [1:0]          pc_src, wb_sel, trap_cause;
  logic                trap, halted;
  logic [InstretW-1:0] instret;
  logic [13:0]         outs;

  logic [6:0] legal_ops [11] = '{OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad,
                                 OpStore, OpImm, OpReg, OpFence, OpSystem};
  logic [6:0] run_ops [10] = '{OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad,
                               OpStore, OpImm, OpReg, OpFence};

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned model_instret = 0;
  bit          dead = 1'b0;

  always #5 clk = ~clk;

  multicycle_seq_ctrl #(
    .MEM_TIMEOUT(MemTimeout),
    .INSTRET_W  (InstretW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .rd_zero     (rd_zero),
    .branch_taken(branch_taken),
    .mem_ready   (mem_ready),
    .mem_err     (mem_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_sel_data(mem_sel_data),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .halted      (halted),
    .instret     (instret)
  );

  assign outs = {mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src, reg_we, wb_sel,
                 trap, trap_cause, halted};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ov(input logic req, input logic we, input logic sel,
                                     input logic ir, input logic pcw, input logic [1:0] ps,
                                     input logic rw, input logic [1:0] ws);
    return {req, we, sel, ir, pcw, ps, rw, ws, 4'b0000};
  endfunction

  function automatic logic [13:0] trap_ov(input logic [1:0] cause);
    return {10'b0, 1'b1, cause, 1'b0};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance.
  task automatic cycle(input string tag, input logic rdy, input logic err,
                       input logic [6:0] op, input logic rdz, input logic bt,
                       input logic [13:0] exp);
    mem_ready = rdy; mem_err = err; opcode = op; rd_zero = rdz; branch_taken = bt;
    @(negedge clk);
    check_eq(tag, 32'(outs), 32'(exp));
    check_eq({tag, " instret"}, instret, model_instret);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_terminal(input string tag, input logic [13:0] exp);
    repeat (3) cycle(tag, 1'b1, 1'($urandom), 7'($urandom), 1'($urandom), 1'($urandom), exp);
    dead = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b1; mem_err = 1'b0;
    @(negedge clk);
    check_eq("reset outs", 32'(outs), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("reset outs held", 32'(outs), 32'd0);
    check_eq("reset instret", instret, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; model_instret = 0; dead = 1'b0;
  endtask

  // bus_err: 0 none, 1 error on the fetch beat, 2 error on the data beat.
  task automatic run_insn(input logic [6:0] op, input int fw, input int mw, input int bus_err);
    logic st, bt, rdz;
    logic [1:0] ps, ws;
    for (int i = 0; i < fw && i < int'(MemTimeout); i++)
      cycle("fetch wait", 1'b0, 1'($urandom), 7'($urandom), 1'($urandom), 1'($urandom),
            ov(1, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    if (fw >= int'(MemTimeout)) begin
      expect_terminal("timeout trap", trap_ov(2'b11));
      return;
    end
    if (bus_err == 1) begin
      cycle("fetch bus err", 1'b1, 1'b1, 7'($urandom), 1'b0, 1'b0,
            ov(1, 0, 0, 0, 0, 2'b00, 0, 2'b00));
      expect_terminal("fetch err trap", trap_ov(2'b10));
      return;
    end
    cycle("fetch", 1'b1, 1'b0, 7'($urandom), 1'($urandom), 1'($urandom),
          ov(1, 0, 0, 1, 0, 2'b00, 0, 2'b00));
    cycle("decode", 1'($urandom), 1'($urandom), op, 1'($urandom), 1'($urandom), 14'd0);
    if (op == OpSystem) begin
      expect_terminal("halt", 14'd1);
      return;
    end
    if (!is_legal(op)) begin
      expect_terminal("illegal trap", trap_ov(2'b01));
      return;
    end
    bt = 1'($urandom);
    if (op == OpBranch || op == OpFence) begin
      ps = (op == OpBranch && bt) ? 2'b01 : 2'b00;
      cycle("exec retire", 1'($urandom), 1'($urandom), op, 1'($urandom), bt,
            ov(0, 0, 0, 0, 1, ps, 0, 2'b00));
      model_instret++;
      return;
    end
    cycle("exec", 1'($urandom), 1'($urandom), op, 1'($urandom), bt, 14'd0);
    if (op == OpLoad || op == OpStore) begin
      st = (op == OpStore);
      for (int i = 0; i < mw; i++)
        cycle("mem wait", 1'b0, 1'($urandom), op, 1'($urandom), 1'($urandom),
              ov(1, st, 1, 0, 0, 2'b00, 0, 2'b00));
      if (bus_err == 2) begin
        cycle("mem bus err", 1'b1, 1'b1, op, 1'b0, 1'b0, ov(1, st, 1, 0, 0, 2'b00, 0, 2'b00));
        expect_terminal("mem err trap", trap_ov(2'b10));
        return;
      end
      cycle("mem done", 1'b1, 1'b0, op, 1'($urandom), 1'($urandom),
            ov(1, st, 1, 0, st, 2'b00, 0, 2'b00));
      if (st) begin
        model_instret++;
        return;
      end
    end
    rdz = 1'($urandom);
    ws = (op == OpLoad) ? 2'b01 : (op == OpJal || op == OpJalr) ? 2'b10 : 2'b00;
    ps = (op == OpJal) ? 2'b01 : (op == OpJalr) ? 2'b10 : 2'b00;
    cycle("wb", 1'($urandom), 1'($urandom), op, rdz, 1'($urandom),
          ov(0, 0, 0, 0, 1, ps, !rdz, ws));
    model_instret++;
  endtask

  initial begin
    opcode = '0; rd_zero = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0; mem_err = 1'b0;
    do_reset();

    run_insn(OpImm, 0, 0, 0);
    run_insn(OpLoad, 0, 3, 0);
    run_insn(OpBranch, 0, 0, 0);
    run_insn(OpBranch, 0, 0, 0);
    for (int n = 0; n < 120; n++)
      run_insn(run_ops[$urandom_range(9)], $urandom_range(3), $urandom_range(3), 0);

    // Ready on the last permitted wait cycle still completes the fetch.
    run_insn(OpImm, int'(MemTimeout) - 1, 0, 0);
    run_insn(OpImm, int'(MemTimeout), 0, 0);
    do_reset();
    run_insn(7'b0000000, 0, 0, 0);
    do_reset();
    run_insn(OpSystem, 1, 0, 0);
    do_reset();
    run_insn(OpImm, 2, 0, 1);
    do_reset();
    run_insn(OpLoad, 0, 2, 2);
    do_reset();

    // Reset while a store is waiting in MEM.
    run_insn(OpReg, 0, 0, 0);
    cycle("st fetch", 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, ov(1, 0, 0, 1, 0, 2'b00, 0, 2'b00));
    cycle("st decode", 1'b0, 1'b0, OpStore, 1'b0, 1'b0, 14'd0);
    cycle("st exec", 1'b0, 1'b0, OpStore, 1'b0, 1'b0, 14'd0);
    cycle("st mem", 1'b0, 1'b0, OpStore, 1'b0, 1'b0, ov(1, 1, 1, 0, 0, 2'b00, 0, 2'b00));
    do_reset();
    run_insn(OpImm, 0, 0, 0);

    for (int n = 0; n < 12; n++) begin
      run_insn(7'($urandom), $urandom_range(2), $urandom_range(2), 0);
      if (dead) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
